data_bus_ctrl: RTL and testbench
================================

Name: data_bus_ctrl

Overview:
- Data-side bus controller directly downstream of the processor's Memory stage.
- Decodes each processor data request (DataAddr/DataOut/ReadData/WriteData) to on-chip word RAM or memory-mapped I/O.
- Returns read data on DataIn and drives DataWaitreq to stall the pipeline for multi-cycle RAM reads.
- RAM has a fixed read latency; MMIO and all writes complete with zero wait.

Parameters:
- WORD_SIZE, 16, data/address width in bits.
- RAM_ADDR_BITS, 8, RAM word-address width; RAM occupies 0x0000 to 2^RAM_ADDR_BITS-1.
- RAM_LATENCY, 2, cycles from RamAddr presentation to valid RamRdData; must be 1 to 15.
- LED_BITS, 10, width of the LED output register.
- SW_BITS, 10, width of the switch input.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- DataAddr  in  WORD_SIZE  processor word address.
- DataOut  in  WORD_SIZE  processor write data.
- ReadData  in  1  processor read request.
- WriteData  in  1  processor write request.
- DataIn  out  WORD_SIZE  read data returned to the processor.
- DataWaitreq  out  1  stall request to the processor.
- RamAddr  out  RAM_ADDR_BITS  RAM word address.
- RamWrData  out  WORD_SIZE  RAM write data.
- RamWe  out  1  RAM write enable; one-cycle pulse.
- RamRdData  in  WORD_SIZE  RAM read data, valid RAM_LATENCY cycles after the address.
- SW  in  SW_BITS  switch inputs.
- LEDR  out  LED_BITS  LED register.

Behaviour:
- Address map, decoded from DataAddr[15:12]:
  - 0x0 is RAM, indexed by DataAddr[RAM_ADDR_BITS-1:0]; 0x0 addresses above the RAM range alias.
  - 0x1 is LEDR, read/write.
  - 0x3 is SW, read-only.
  - 0x4 is TIMER, a free-running 16-bit counter; read returns the count, any write clears it to 0.
  - All other regions are unmapped: reads return 0, writes are ignored, zero wait.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - RAM read: DataWaitreq=1 combinationally in the same cycle; RamAddr driven; counter loads RAM_LATENCY-1; go to WAIT, or to RESP if RAM_LATENCY=1.
  - RAM write: RamWe=1 and RamWrData=DataOut that cycle, DataWaitreq=0, stay in IDLE.
  - MMIO read: DataIn driven combinationally, DataWaitreq=0.
  - MMIO write to LEDR: LEDR<=DataOut[LED_BITS-1:0] at the edge.
- WAIT: DataWaitreq=1; RamAddr held from a registered copy of the address; counter decrements; go to RESP when the counter reaches 0.
- RESP: DataWaitreq=0; DataIn=RamRdData; return to IDLE next cycle (the processor advances on this edge).
- Consequence: RAM read total latency is RAM_LATENCY+1 cycles, and DataWaitreq is high for exactly RAM_LATENCY cycles.
- ReadData and WriteData both high: write takes priority, read is ignored, DataIn=0, zero wait.
- While in WAIT/RESP, new input requests are ignored; the processor holds its inputs stable while stalled.
- DataIn is 0 whenever no read is completing that cycle.
- TIMER increments every cycle and wraps 0xFFFF to 0x0000; a clearing write takes precedence over the increment.
- Reset values: state IDLE, counter 0, LEDR 0, TIMER 0; DataWaitreq=0, RamWe=0, DataIn=0, RamAddr=0, RamWrData=0.
- Reset asserted during WAIT or RESP aborts the read: IDLE next cycle, no response delivered.

Test Plan:
1. RAM_LATENCY=2; write 0x1234 to addr 0x0005 -> RamWe pulses one cycle with RamAddr=5, RamWrData=0x1234, DataWaitreq stays 0.
2. Read addr 0x0005 (RAM returns 0x1234) -> DataWaitreq high for exactly 2 cycles, then DataIn=0x1234 with DataWaitreq=0, FSM back to IDLE.
3. Write 0x03FF to 0x1000, then read 0x1000 -> LEDR=0x3FF next edge; read returns 0x03FF with zero wait. Set SW=0x2A5, read 0x3000 -> DataIn=0x02A5.
4. Write 0x4000 at cycle N -> TIMER reads 0 at N+1 and 3 at N+4; preload TIMER to 0xFFFF -> next read 0x0000.
5. Read 0x7000 -> DataIn=0, no wait. Assert ReadData and WriteData together to 0x1000 with DataOut=0x5 -> LEDR=5, DataIn=0.
6. Assert Reset in the first WAIT cycle of a RAM read -> DataWaitreq=0 and state IDLE next cycle, LEDR=0; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller behind the Memory stage: routes processor loads/stores
// to word RAM (fixed read latency, stalls the pipeline) or to zero-wait MMIO.
module data_bus_ctrl #(
  parameter int WORD_SIZE     = 16,
  parameter int RAM_ADDR_BITS = 8,
  parameter int RAM_LATENCY   = 2,
  parameter int LED_BITS      = 10,
  parameter int SW_BITS       = 10
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WORD_SIZE-1:0]     DataAddr,
  input  logic [WORD_SIZE-1:0]     DataOut,
  input  logic                     ReadData,
  input  logic                     WriteData,
  output logic [WORD_SIZE-1:0]     DataIn,
  output logic                     DataWaitreq,
  output logic [RAM_ADDR_BITS-1:0] RamAddr,
  output logic [WORD_SIZE-1:0]     RamWrData,
  output logic                     RamWe,
  input  logic [WORD_SIZE-1:0]     RamRdData,
  input  logic [SW_BITS-1:0]       SW,
  output logic [LED_BITS-1:0]      LEDR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1     = 4'(RAM_LATENCY - 1);
  localparam logic [3:0] REG_RAM    = 4'h0;
  localparam logic [3:0] REG_LED    = 4'h1;
  localparam logic [3:0] REG_SW     = 4'h3;
  localparam logic [3:0] REG_TIMER  = 4'h4;

  state_t                   state_q;
  logic [3:0]               cnt_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [LED_BITS-1:0]      led_q;
  logic [15:0]              timer_q;
  logic [15:0]              timer_d;

  logic [3:0]               region;
  logic [RAM_ADDR_BITS-1:0] ram_index;
  logic                     idle_req;
  logic                     wr_req;
  logic                     rd_req;
  logic                     ram_rd;
  logic                     ram_wr;
  logic [WORD_SIZE-1:0]     mmio_rdata;
  logic                     unused_addr_bits;

  assign region    = DataAddr[WORD_SIZE-1 -: 4];
  assign ram_index = DataAddr[RAM_ADDR_BITS-1:0];
  // RAM region bits above the index are don't-care: those addresses alias.
  assign unused_addr_bits = ^DataAddr[WORD_SIZE-5:RAM_ADDR_BITS];

  // Requests are only accepted in IDLE; a write always wins over a simultaneous read.
  assign idle_req = (state_q == S_IDLE) && !Reset;
  assign wr_req   = idle_req && WriteData;
  assign rd_req   = idle_req && ReadData && !WriteData;
  assign ram_rd   = rd_req && (region == REG_RAM);
  assign ram_wr   = wr_req && (region == REG_RAM);

  always_comb begin
    timer_d = timer_q + 16'd1;
    if (wr_req && (region == REG_TIMER)) begin
      timer_d = 16'd0;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (region)
      REG_LED:   mmio_rdata = WORD_SIZE'(led_q);
      REG_SW:    mmio_rdata = WORD_SIZE'(SW);
      REG_TIMER: mmio_rdata = WORD_SIZE'(timer_q);
      default:   mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      led_q   <= '0;
      timer_q <= 16'd0;
    end else begin
      timer_q <= timer_d;
      if (wr_req && (region == REG_LED)) begin
        led_q <= DataOut[LED_BITS-1:0];
      end
      case (state_q)
        S_IDLE: begin
          if (ram_rd) begin
            addr_q  <= ram_index;
            cnt_q   <= LAT_M1;
            state_q <= (RAM_LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter holds the WAIT cycles still to run including this one.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus outputs: IDLE responses are combinational so MMIO and writes never stall.
  always_comb begin
    DataIn      = '0;
    DataWaitreq = 1'b0;
    RamAddr     = '0;
    RamWrData   = '0;
    RamWe       = 1'b0;
    if (Reset) begin
      DataIn      = '0;
      DataWaitreq = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ram_rd) begin
            DataWaitreq = 1'b1;
            RamAddr     = ram_index;
          end else if (ram_wr) begin
            RamWe     = 1'b1;
            RamAddr   = ram_index;
            RamWrData = DataOut;
          end else if (rd_req) begin
            DataIn = mmio_rdata;
          end else begin
            DataIn = '0;
          end
        end
        S_WAIT: begin
          DataWaitreq = 1'b1;
          RamAddr     = addr_q;
        end
        S_RESP: begin
          DataIn  = RamRdData;
          RamAddr = addr_q;
        end
        default: begin
          DataIn      = '0;
          DataWaitreq = 1'b0;
        end
      endcase
    end
  end

  assign LEDR = led_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl with a small 2-cycle-latency RAM model attached.
module tb_data_bus_ctrl;

  logic        Clock;
  logic        Reset;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic        ReadData;
  logic        WriteData;
  logic [15:0] DataIn;
  logic        DataWaitreq;
  logic [7:0]  RamAddr;
  logic [15:0] RamWrData;
  logic        RamWe;
  logic [15:0] RamRdData;
  logic [9:0]  SW;
  logic [9:0]  LEDR;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  logic [15:0] pipe1;
  logic [15:0] pipe2;

  data_bus_ctrl dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
    .DataWaitreq(DataWaitreq), .RamAddr(RamAddr), .RamWrData(RamWrData),
    .RamWe(RamWe), .RamRdData(RamRdData), .SW(SW), .LEDR(LEDR)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: data for an address appears two cycles after it is presented.
  always @(posedge Clock) begin
    if (RamWe) mem[RamAddr] <= RamWrData;
    pipe1 <= mem[RamAddr];
    pipe2 <= pipe1;
  end
  assign RamRdData = pipe2;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    pipe1 = 16'h0000;
    pipe2 = 16'h0000;
    Reset = 1'b1; DataAddr = 16'h0000; DataOut = 16'h0000;
    ReadData = 1'b0; WriteData = 1'b0; SW = 10'h000;
    tick(); tick();
    #1;
    chk("rst_waitreq", 16'(DataWaitreq), 16'h0000);
    chk("rst_datain", DataIn, 16'h0000);
    chk("rst_ramwe", 16'(RamWe), 16'h0000);
    chk("rst_ledr", 16'(LEDR), 16'h0000);
    chk("rst_ramaddr", 16'(RamAddr), 16'h0000);
    chk("rst_timer_read", 16'(dut.timer_q), 16'h0000);

    // 1: RAM write
    tick(); Reset = 1'b0;
    tick();
    WriteData = 1'b1; DataAddr = 16'h0005; DataOut = 16'h1234;
    #1;
    chk("wr_ramwe", 16'(RamWe), 16'h0001);
    chk("wr_ramaddr", 16'(RamAddr), 16'h0005);
    chk("wr_ramwrdata", RamWrData, 16'h1234);
    chk("wr_waitreq", 16'(DataWaitreq), 16'h0000);
    tick();
    WriteData = 1'b0;
    #1;
    chk("wr_ramwe_pulse", 16'(RamWe), 16'h0000);

    // 2: RAM read, two stall cycles then data
    ReadData = 1'b1; DataAddr = 16'h0005;
    #1;
    chk("rd_wait1", 16'(DataWaitreq), 16'h0001);
    chk("rd_wait1_datain", DataIn, 16'h0000);
    tick(); #1;
    chk("rd_wait2", 16'(DataWaitreq), 16'h0001);
    chk("rd_wait2_ramaddr", 16'(RamAddr), 16'h0005);
    tick(); #1;
    chk("rd_resp_wait", 16'(DataWaitreq), 16'h0000);
    chk("rd_resp_data", DataIn, 16'h1234);
    tick();
    ReadData = 1'b0;
    #1;
    chk("rd_back_idle", 16'(dut.state_q), 16'h0000);
    chk("rd_idle_datain", DataIn, 16'h0000);

    // 3: LEDR and SW
    WriteData = 1'b1; DataAddr = 16'h1000; DataOut = 16'h03FF;
    #1;
    chk("led_before_edge", 16'(LEDR), 16'h0000);
    tick();
    WriteData = 1'b0; ReadData = 1'b1;
    #1;
    chk("led_written", 16'(LEDR), 16'h03FF);
    chk("led_read", DataIn, 16'h03FF);
    chk("led_read_wait", 16'(DataWaitreq), 16'h0000);
    SW = 10'h2A5; DataAddr = 16'h3000;
    #1;
    chk("sw_read", DataIn, 16'h02A5);

    // 4: TIMER clear, count and wrap
    ReadData = 1'b0; WriteData = 1'b1; DataAddr = 16'h4000;
    tick();
    WriteData = 1'b0; ReadData = 1'b1;
    #1;
    chk("timer_n1", DataIn, 16'h0000);
    tick(); tick(); tick();
    #1;
    chk("timer_n4", DataIn, 16'h0003);
    repeat (65532) tick();
    #1;
    chk("timer_max", DataIn, 16'hFFFF);
    tick(); #1;
    chk("timer_wrap", DataIn, 16'h0000);

    // 5: unmapped read, simultaneous read+write
    DataAddr = 16'h7000;
    #1;
    chk("unmapped_data", DataIn, 16'h0000);
    chk("unmapped_wait", 16'(DataWaitreq), 16'h0000);
    WriteData = 1'b1; DataAddr = 16'h1000; DataOut = 16'h0005;
    #1;
    chk("rdwr_datain", DataIn, 16'h0000);
    chk("rdwr_wait", 16'(DataWaitreq), 16'h0000);
    tick();
    WriteData = 1'b0; ReadData = 1'b0;
    #1;
    chk("rdwr_led", 16'(LEDR), 16'h0005);
    // Aliased RAM write with both strobes: write wins, no stall.
    ReadData = 1'b1; WriteData = 1'b1; DataAddr = 16'h0105; DataOut = 16'hBEEF;
    #1;
    chk("alias_ramwe", 16'(RamWe), 16'h0001);
    chk("alias_ramaddr", 16'(RamAddr), 16'h0005);
    chk("alias_wait", 16'(DataWaitreq), 16'h0000);
    tick();
    ReadData = 1'b0; WriteData = 1'b0;

    // 6: reset aborts a read in WAIT
    ReadData = 1'b1; DataAddr = 16'h0005;
    tick();
    #1;
    chk("abort_in_wait", 16'(DataWaitreq), 16'h0001);
    Reset = 1'b1;
    #1;
    chk("abort_rst_wait", 16'(DataWaitreq), 16'h0000);
    tick();
    Reset = 1'b0; ReadData = 1'b0;
    #1;
    chk("abort_state", 16'(dut.state_q), 16'h0000);
    chk("abort_wait", 16'(DataWaitreq), 16'h0000);
    chk("abort_led", 16'(LEDR), 16'h0000);
    chk("abort_datain", DataIn, 16'h0000);
    ReadData = 1'b1; DataAddr = 16'h0F05;
    #1;
    chk("fresh_wait1", 16'(DataWaitreq), 16'h0001);
    tick(); #1;
    chk("fresh_wait2", 16'(DataWaitreq), 16'h0001);
    tick(); #1;
    chk("fresh_resp_wait", 16'(DataWaitreq), 16'h0000);
    chk("fresh_resp_data", DataIn, 16'hBEEF);
    tick();
    ReadData = 1'b0;
    #1;
    chk("fresh_idle_datain", DataIn, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
